// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing one L2 request port between L1I (port 0) and L1D (port 1).
// Latency: L2 request one cycle after IDLE sees it; response routed back combinationally.
// Backpressure: requests are level-held until ready; a watchdog bounds a silent L2.
module l2_request_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BLOCK_SIZE     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ADDR_WIDTH-1:0]              p0_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   p0_data_in,
    input  logic                               p0_read,
    input  logic                               p0_write,
    output logic                               p0_ready,
    output logic                               p0_hit,
    output logic                               p0_block_valid,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   p0_block_data,
    input  logic [ADDR_WIDTH-1:0]              p1_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   p1_data_in,
    input  logic                               p1_read,
    input  logic                               p1_write,
    output logic                               p1_ready,
    output logic                               p1_hit,
    output logic                               p1_block_valid,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   p1_block_data,
    output logic [ADDR_WIDTH-1:0]              l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   l2_data_in,
    output logic                               l2_read,
    output logic                               l2_write,
    input  logic                               l2_ready,
    input  logic                               l2_hit,
    input  logic                               l2_block_valid,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   l2_block_data,
    output logic                               grant,
    output logic                               busy,
    output logic                               timeout_err
);
    localparam int BW   = BLOCK_SIZE * DATA_WIDTH;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;
    logic [WD_W-1:0]       wdog;

    logic                  p0_req;
    logic                  p1_req;
    logic                  win;
    logic                  win_read;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [BW-1:0]         win_data;
    logic                  in_busy;
    logic                  resp_fire;
    logic                  wd_fire;
    logic                  done;

    assign p0_req = p0_read | p0_write;
    assign p1_req = p1_read | p1_write;

    // On a tie the port that lost the previous arbitration wins.
    always_comb begin
        win = (p0_req & p1_req) ? ~last_grant : p1_req;
        if (win) begin
            win_read  = p1_read;
            win_write = p1_write;
            win_addr  = p1_addr;
            win_data  = p1_data_in;
        end else begin
            win_read  = p0_read;
            win_write = p0_write;
            win_addr  = p0_addr;
            win_data  = p0_data_in;
        end
    end

    assign in_busy   = (state == BUSY);
    assign busy      = in_busy;
    // Gating with rst_n keeps an abandoned transaction from signalling completion.
    assign resp_fire = in_busy & rst_n & l2_ready;
    assign wd_fire   = in_busy & rst_n & ~l2_ready & (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign done      = resp_fire | wd_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            timeout_err <= 1'b0;
            l2_read     <= 1'b0;
            l2_write    <= 1'b0;
            l2_addr     <= '0;
            l2_data_in  <= '0;
            wdog        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req | p1_req) begin
                        state      <= BUSY;
                        grant      <= win;
                        last_grant <= win;
                        l2_addr    <= win_addr;
                        l2_data_in <= win_data;
                        l2_write   <= win_write;
                        l2_read    <= win_read & ~win_write;
                        wdog       <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state    <= RELEASE;
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        if (wd_fire) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign p0_ready       = done & ~grant;
    assign p1_ready       = done & grant;
    assign p0_hit         = resp_fire & ~grant & l2_hit;
    assign p1_hit         = resp_fire & grant & l2_hit;
    assign p0_block_valid = resp_fire & ~grant & l2_block_valid;
    assign p1_block_valid = resp_fire & grant & l2_block_valid;
    assign p0_block_data  = (resp_fire & ~grant) ? l2_block_data : '0;
    assign p1_block_data  = (resp_fire & grant) ? l2_block_data : '0;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized bench for l2_request_arbiter against a transaction-level reference model.
module tb_l2_request_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 4;
    localparam int TO = 8;
    localparam int BW = BS * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr_i [2];
    logic [BW-1:0] wdat_i [2];
    logic [1:0]    rd_i = '0;
    logic [1:0]    wr_i = '0;
    logic [1:0]    rdy_o, hit_o, bv_o;
    logic [BW-1:0] bd_o0, bd_o1;
    logic [AW-1:0] l2_addr;
    logic [BW-1:0] l2_data_in;
    logic          l2_read, l2_write;
    logic          l2_ready = 1'b0, l2_hit = 1'b0, l2_block_valid = 1'b0;
    logic [BW-1:0] l2_block_data = '0;
    logic          grant, busy, timeout_err;

    always #5 clk = ~clk;

    l2_request_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(addr_i[0]), .p0_data_in(wdat_i[0]), .p0_read(rd_i[0]), .p0_write(wr_i[0]),
        .p0_ready(rdy_o[0]), .p0_hit(hit_o[0]), .p0_block_valid(bv_o[0]), .p0_block_data(bd_o0),
        .p1_addr(addr_i[1]), .p1_data_in(wdat_i[1]), .p1_read(rd_i[1]), .p1_write(wr_i[1]),
        .p1_ready(rdy_o[1]), .p1_hit(hit_o[1]), .p1_block_valid(bv_o[1]), .p1_block_data(bd_o1),
        .l2_addr(l2_addr), .l2_data_in(l2_data_in), .l2_read(l2_read), .l2_write(l2_write),
        .l2_ready(l2_ready), .l2_hit(l2_hit), .l2_block_valid(l2_block_valid),
        .l2_block_data(l2_block_data),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, its owner, age and latched request.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic          rd;
        logic          wr;
    } req_t;

    bit   m_active, m_cool, m_last, m_grant, m_terr;
    int   m_age;
    req_t m_lat;

    // Requester agents and L2 responder knobs.
    bit            hold [2];
    bit            h_rd [2];
    bit            h_wr [2];
    logic [AW-1:0] h_addr [2];
    logic [BW-1:0] h_dat [2];
    bit            prev_rdy [2];
    int            start_pct = 0;
    int            mode = 3;
    bit            rand_rst = 0;
    int            l2_lat = 0;

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] d;
        for (int w = 0; w < BS; w++) d[w*DW +: DW] = $urandom;
        return d;
    endfunction

    task automatic set_req(input int n, input bit rd, input bit wr, input logic [AW-1:0] a);
        hold[n]   = 1;
        h_rd[n]   = rd;
        h_wr[n]   = wr;
        h_addr[n] = a;
        h_dat[n]  = rand_block();
    endtask

    task automatic model_reset();
        m_active = 0; m_cool = 0; m_last = 1; m_grant = 0; m_terr = 0; m_age = 0; m_lat = '0;
    endtask

    task automatic step();
        bit            done;
        bit            req [2];
        bit            pick;
        bit            e_rdy [2];
        logic [BW-1:0] e_bd [2];
        int            kind;
        for (int n = 0; n < 2; n++) begin
            if (prev_rdy[n]) hold[n] = 0;
            if (!hold[n] && $urandom_range(0, 99) < start_pct) begin
                kind = $urandom_range(0, 2);
                set_req(n, kind != 1, kind != 0, $urandom);
            end
            rd_i[n]   = hold[n] & h_rd[n];
            wr_i[n]   = hold[n] & h_wr[n];
            addr_i[n] = h_addr[n];
            wdat_i[n] = h_dat[n];
        end
        if (m_active && m_age == 0)
            l2_lat = (mode == 0) ? $urandom_range(1, 11) : (mode == 2) ? 0 : 2;
        if (m_active) l2_ready = (l2_lat != 0) && (m_age == l2_lat - 1);
        else          l2_ready = (mode == 0 || mode == 3) && ($urandom_range(0, 3) == 0);
        l2_hit         = (mode == 0) ? 1'($urandom) : 1'b1;
        l2_block_valid = (mode == 0) ? 1'($urandom) : 1'b1;
        l2_block_data  = rand_block();
        if (mode == 3) l2_block_data[31:0] = 32'hDEAD_BEEF;
        if (rand_rst) rst_n = ($urandom_range(0, 79) != 0);

        #2;
        done = rst_n && m_active && (l2_ready || m_age == TO - 1);
        for (int n = 0; n < 2; n++) begin
            e_rdy[n] = done && (m_grant == n[0]);
            e_bd[n]  = (e_rdy[n] && l2_ready) ? l2_block_data : '0;
        end
        check("busy", BW'(busy), BW'(m_active));
        check("grant", BW'(grant), BW'(m_grant));
        check("timeout_err", BW'(timeout_err), BW'(m_terr));
        check("l2_read", BW'(l2_read), BW'(m_active & m_lat.rd));
        check("l2_write", BW'(l2_write), BW'(m_active & m_lat.wr));
        check("l2_addr", BW'(l2_addr), BW'(m_lat.addr));
        check("l2_data_in", l2_data_in, m_lat.data);
        check("p0_ready", BW'(rdy_o[0]), BW'(e_rdy[0]));
        check("p1_ready", BW'(rdy_o[1]), BW'(e_rdy[1]));
        check("p0_hit", BW'(hit_o[0]), BW'(e_rdy[0] & l2_ready & l2_hit));
        check("p1_hit", BW'(hit_o[1]), BW'(e_rdy[1] & l2_ready & l2_hit));
        check("p0_block_valid", BW'(bv_o[0]), BW'(e_rdy[0] & l2_ready & l2_block_valid));
        check("p1_block_valid", BW'(bv_o[1]), BW'(e_rdy[1] & l2_ready & l2_block_valid));
        check("p0_block_data", bd_o0, e_bd[0]);
        check("p1_block_data", bd_o1, e_bd[1]);

        // Advance the model across the coming edge.
        req[0] = rd_i[0] | wr_i[0];
        req[1] = rd_i[1] | wr_i[1];
        if (!rst_n) begin
            model_reset();
        end else if (m_active) begin
            if (done) begin
                if (!l2_ready) m_terr = 1;
                m_active = 0;
                m_cool   = 1;
            end else begin
                m_age++;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (req[0] || req[1]) begin
            pick          = (req[0] && req[1]) ? !m_last : req[1];
            m_lat.addr    = addr_i[pick];
            m_lat.data    = wdat_i[pick];
            m_lat.wr      = wr_i[pick];
            m_lat.rd      = rd_i[pick] & ~wr_i[pick];
            m_active      = 1;
            m_age         = 0;
            m_grant       = pick;
            m_last        = pick;
        end
        prev_rdy[0] = e_rdy[0];
        prev_rdy[1] = e_rdy[1];
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            hold[n] = 0; h_rd[n] = 0; h_wr[n] = 0; h_addr[n] = '0; h_dat[n] = '0;
            prev_rdy[n] = 0; addr_i[n] = '0; wdat_i[n] = '0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with p0 requesting, then first grant.
        mode = 3;
        set_req(0, 1, 0, 32'h0000_0100);
        run(2);
        rst_n = 1'b1;
        run(8);

        // Single read hit on port 1.
        set_req(1, 1, 0, 32'h0000_1040);
        run(8);

        // Simultaneous requests right after reset.
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        set_req(0, 1, 0, $urandom);
        set_req(1, 0, 1, $urandom);
        run(12);

        // Continuous contention, L2 answering after 2 cycles.
        mode = 1;
        start_pct = 100;
        run(26);
        start_pct = 0;
        run(8);

        // Write priority with stale l2_ready pulses in IDLE.
        mode = 3;
        set_req(0, 1, 1, $urandom);
        run(10);

        // Watchdog: L2 never answers, then a normal port 1 request.
        mode = 2;
        set_req(0, 1, 0, $urandom);
        run(14);
        mode = 3;
        set_req(1, 1, 0, $urandom);
        run(8);

        // Randomized traffic with mid-flight resets and timeouts.
        mode = 0;
        start_pct = 30;
        rand_rst = 1;
        run(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
